// File: rtl/display_capture.sv
// Captures a four-digit multiplexed hex display into a 16-bit frame.
// Optional macro DISPLAY_CAPTURE_STABLE_EN: publish only repeated frames.
module display_capture #(
    parameter int SETTLE = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digit_select,
    input  logic [3:0]  mux1_o,
    output logic [15:0] count,
    output logic        frame_valid,
    output logic        seq_err,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {HUNT, D2, D1, D0} state_t;

    state_t      state_q, state_d;
    logic [3:0]  prev_q, prev_d;
    logic [3:0]  settle_q, settle_d;
    logic [11:0] part_q, part_d;
    logic [15:0] count_q, count_d;
    logic        fv_q, fv_d;
    logic        err_q, err_d;
    logic [7:0]  fcnt_q, fcnt_d;

    logic        dwell_done;
    logic        is3, is2, is1, is0;
    logic        onehot, bad;
    logic        complete;
    logic [15:0] frame;

`ifdef DISPLAY_CAPTURE_STABLE_EN
    logic [15:0] ref_q, ref_d;
    logic        ref_vld_q, ref_vld_d;
`endif

    assign is3    = (digit_select == 4'b0111);
    assign is2    = (digit_select == 4'b1011);
    assign is1    = (digit_select == 4'b1101);
    assign is0    = (digit_select == 4'b1110);
    assign onehot = is3 | is2 | is1 | is0;
    assign bad    = !onehot && (digit_select != 4'b1111);
    assign frame  = {part_q, mux1_o};

    // Counter saturates so a long dwell is never accepted twice.
    always_comb begin
        prev_d = digit_select;
        if (digit_select == prev_q) begin
            settle_d = (settle_q == 4'hF) ? 4'hF : settle_q + 4'd1;
        end else begin
            settle_d = 4'd1;
        end
        dwell_done = (settle_d == 4'(SETTLE));
    end

    always_comb begin
        state_d  = state_q;
        part_d   = part_q;
        err_d    = err_q;
        complete = 1'b0;
        if (dwell_done && bad) begin
            err_d   = 1'b1;
            state_d = HUNT;
        end else if (dwell_done && onehot) begin
            unique case (state_q)
                HUNT: begin
                    if (is3) begin
                        part_d[11:8] = mux1_o;
                        state_d      = D2;
                    end
                end
                D2: begin
                    if (is2) begin
                        part_d[7:4] = mux1_o;
                        state_d     = D1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                D1: begin
                    if (is1) begin
                        part_d[3:0] = mux1_o;
                        state_d     = D0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                D0: begin
                    if (is0) begin
                        complete = 1'b1;
                        state_d  = HUNT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
            // Out-of-order digit: restart at D2 only if it was digit 3.
            if (state_q != HUNT && !complete && state_d == state_q) begin
                if (is3) begin
                    part_d[11:8] = mux1_o;
                    state_d      = D2;
                end else begin
                    state_d = HUNT;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        fv_d    = 1'b0;
        fcnt_d  = fcnt_q;
`ifdef DISPLAY_CAPTURE_STABLE_EN
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        if (complete) begin
            ref_d     = frame;
            ref_vld_d = 1'b1;
            if (ref_vld_q && frame == ref_q) begin
                count_d = frame;
                fv_d    = 1'b1;
                fcnt_d  = fcnt_q + 8'd1;
            end
        end
`else
        if (complete) begin
            count_d = frame;
            fv_d    = 1'b1;
            fcnt_d  = fcnt_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HUNT;
            prev_q   <= 4'hF;
            settle_q <= 4'd0;
            part_q   <= 12'd0;
            count_q  <= 16'd0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            fcnt_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            settle_q <= settle_d;
            part_q   <= part_d;
            count_q  <= count_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            fcnt_q   <= fcnt_d;
        end
    end

`ifdef DISPLAY_CAPTURE_STABLE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_q     <= 16'd0;
            ref_vld_q <= 1'b0;
        end else begin
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
        end
    end
`endif

    assign count       = count_q;
    assign frame_valid = fv_q;
    assign seq_err     = err_q;
    assign frame_cnt   = fcnt_q;

endmodule
